// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file definitions: default widths, register count and the
// write-arbiter state encoding.
package regfile_write_arbiter_pkg;

    localparam int unsigned RF_DATA_W   = 16;
    localparam int unsigned RF_ADDR_W   = 4;
    localparam int unsigned RF_NUM_REGS = 1 << RF_ADDR_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: Pointer=0 favours requester 0, Pointer=1 favours
// requester 1 when both are requesting.
module rr_arbiter2 (
    input  logic Req0,
    input  logic Req1,
    input  logic Pointer,
    output logic Grant0,
    output logic Grant1
);

    always_comb begin
        Grant0 = Req0 && (!Req1 || !Pointer);
        Grant1 = Req1 && (!Req0 ||  Pointer);
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: two round-robin requesters, a full-file
// zeroing sequence, and read-after-write hazard flags for two read ports.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Data0,
    input  logic [DATA_W-1:0] Data1,
    output logic              Ack0,
    output logic              Ack1,
    input  logic              ClearReq,
    output logic              ClearDone,
    output logic              WriteEnable,
    output logic [ADDR_W-1:0] SelectInput,
    output logic [DATA_W-1:0] In,
    input  logic [ADDR_W-1:0] SelectA,
    input  logic [ADDR_W-1:0] SelectB,
    output logic              HazardA,
    output logic              HazardB,
    output logic              Busy
);

    localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

    arb_state_e        state_q, state_d;
    logic              ptr_q,   ptr_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] sel_q,   sel_d;
    logic [DATA_W-1:0] in_q,    in_d;
    logic              done_q,  done_d;
    logic              busy_q,  busy_d;

    logic grant0, grant1;
    logic ack0,   ack1;

    rr_arbiter2 u_rr_arbiter2 (
        .Req0    (Req0),
        .Req1    (Req1),
        .Pointer (ptr_q),
        .Grant0  (grant0),
        .Grant1  (grant1)
    );

    // A clear request pre-empts both requesters; reset suppresses all acks.
    always_comb begin
        ack0 = Reset && (state_q == ST_IDLE) && !ClearReq && grant0;
        ack1 = Reset && (state_q == ST_IDLE) && !ClearReq && grant1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        sel_d   = sel_q;
        in_d    = in_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ClearReq) begin
                    // Address 0 goes out on the first CLEAR cycle itself.
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    we_d    = 1'b1;
                    sel_d   = '0;
                    in_d    = '0;
                end else if (ack0) begin
                    we_d  = 1'b1;
                    sel_d = Addr0;
                    in_d  = Data0;
                    ptr_d = 1'b1;
                end else if (ack1) begin
                    we_d  = 1'b1;
                    sel_d = Addr1;
                    in_d  = Data1;
                    ptr_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    we_d  = 1'b1;
                    sel_d = cnt_q + CNT_ONE;
                    in_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            in_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            in_q    <= in_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        Ack0        = ack0;
        Ack1        = ack1;
        WriteEnable = we_q;
        SelectInput = sel_q;
        In          = in_q;
        ClearDone   = done_q;
        Busy        = busy_q;
        HazardA     = (we_q && (sel_q == SelectA)) || (state_q == ST_CLEAR);
        HazardB     = (we_q && (sel_q == SelectB)) || (state_q == ST_CLEAR);
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    localparam int unsigned DW = RF_DATA_W;
    localparam int unsigned AW = RF_ADDR_W;
    localparam int unsigned NR = RF_NUM_REGS;

    logic          Clock = 1'b0;
    logic          Reset, Req0, Req1, ClearReq;
    logic [AW-1:0] Addr0, Addr1, SelectA, SelectB;
    logic [DW-1:0] Data0, Data1;
    logic          Ack0, Ack1, ClearDone, WriteEnable, HazardA, HazardB, Busy;
    logic [AW-1:0] SelectInput;
    logic [DW-1:0] In;

    always #5 Clock = ~Clock;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0), .Req1(Req1), .Addr0(Addr0), .Addr1(Addr1),
        .Data0(Data0), .Data1(Data1), .Ack0(Ack0), .Ack1(Ack1),
        .ClearReq(ClearReq), .ClearDone(ClearDone),
        .WriteEnable(WriteEnable), .SelectInput(SelectInput), .In(In),
        .SelectA(SelectA), .SelectB(SelectB),
        .HazardA(HazardA), .HazardB(HazardB), .Busy(Busy)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: what is currently presented on the write port, whether
    // a zeroing sweep is running and which address it reaches next.
    bit            m_clearing;
    int unsigned   m_clear_next;
    int            m_prio;
    bit            m_wr_valid;
    logic [AW-1:0] m_wr_addr;
    logic [DW-1:0] m_wr_data;
    bit            m_done;
    logic [DW-1:0] ref_regs  [NR];
    logic [DW-1:0] phys_regs [NR];
    bit            e_ack0, e_ack1;
    logic          o_ack0, o_ack1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clearing   = 1'b0;
        m_clear_next = 0;
        m_prio       = 0;
        m_wr_valid   = 1'b0;
        m_wr_addr    = '0;
        m_wr_data    = '0;
        m_done       = 1'b0;
    endtask

    task automatic model_issue(input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_wr_valid  = 1'b1;
        m_wr_addr   = a;
        m_wr_data   = d;
        ref_regs[a] = d;
    endtask

    // One clock cycle: inputs are already driven just after a falling edge.
    task automatic step();
        int w;
        #1;
        w = -1;
        if (Reset && !m_clearing && !ClearReq) begin
            if (Req0 && Req1) w = m_prio;
            else if (Req0)    w = 0;
            else if (Req1)    w = 1;
        end
        e_ack0 = (w == 0);
        e_ack1 = (w == 1);
        o_ack0 = Ack0;
        o_ack1 = Ack1;
        chk("ack0", 64'(Ack0), 64'(e_ack0));
        chk("ack1", 64'(Ack1), 64'(e_ack1));
        chk("hazard_a", 64'(HazardA), 64'(m_clearing || (m_wr_valid && m_wr_addr == SelectA)));
        chk("hazard_b", 64'(HazardB), 64'(m_clearing || (m_wr_valid && m_wr_addr == SelectB)));
        if (WriteEnable === 1'b1) phys_regs[SelectInput] = In;

        if (!Reset) begin
            model_reset();
        end else if (m_clearing) begin
            m_done = 1'b0;
            if (m_clear_next < NR) begin
                model_issue(AW'(m_clear_next), '0);
                m_clear_next++;
            end else begin
                m_clearing = 1'b0;
                m_done     = 1'b1;
                m_wr_valid = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (ClearReq) begin
                m_clearing   = 1'b1;
                m_clear_next = 1;
                model_issue('0, '0);
            end else if (w == 0) begin
                model_issue(Addr0, Data0);
                m_prio = 1;
            end else if (w == 1) begin
                model_issue(Addr1, Data1);
                m_prio = 0;
            end else begin
                m_wr_valid = 1'b0;
            end
        end

        @(posedge Clock);
        #1;
        chk("write_enable", 64'(WriteEnable), 64'(m_wr_valid));
        chk("select_input", 64'(SelectInput), 64'(m_wr_addr));
        chk("in_data",      64'(In),          64'(m_wr_data));
        chk("busy",         64'(Busy),        64'(m_clearing));
        chk("clear_done",   64'(ClearDone),   64'(m_done));
        @(negedge Clock);
    endtask

    initial begin
        Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0; ClearReq = 1'b0;
        Addr0 = '0; Addr1 = '0; Data0 = '0; Data1 = '0;
        SelectA = '0; SelectB = '0;
        model_reset();
        for (int i = 0; i < int'(NR); i++) begin
            ref_regs[i]  = '0;
            phys_regs[i] = '0;
        end
        @(negedge Clock);

        // Reset state; a request during reset must not be acknowledged.
        step();
        Req0 = 1'b1; Addr0 = 4'd6;
        step();
        chk("reset_no_ack0", 64'(o_ack0), 64'd0);
        chk("reset_we", 64'(WriteEnable), 64'd0);
        chk("reset_sel", 64'(SelectInput), 64'd0);

        // Single requester, latency-1 write, then an idle cycle holding values.
        Reset = 1'b1; Addr0 = 4'd3; Data0 = 16'hBEEF;
        step();
        chk("single_ack0", 64'(o_ack0), 64'd1);
        chk("single_sel", 64'(SelectInput), 64'd3);
        chk("single_in", 64'(In), 64'hBEEF);
        Req0 = 1'b0;
        step();
        chk("idle_hold_in", 64'(In), 64'hBEEF);

        // Both requesting for four cycles after reset: strict alternation.
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            Req0 = 1'b1; Req1 = 1'b1;
            Addr0 = AW'(k); Addr1 = AW'(k + 8);
            Data0 = DW'(16'h0A00 + k); Data1 = DW'(16'h0B00 + k);
            step();
            chk("rr_ack0", 64'(o_ack0), 64'((k % 2) == 0));
            chk("rr_ack1", 64'(o_ack1), 64'((k % 2) == 1));
            chk("rr_we",   64'(WriteEnable), 64'd1);
        end
        Req0 = 1'b0; Req1 = 1'b0;
        step();

        // Same destination from both: winner then loser, loser's data remains.
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        Req0 = 1'b1; Req1 = 1'b1; Addr0 = 4'd5; Addr1 = 4'd5;
        Data0 = 16'h1111; Data1 = 16'h2222;
        step();
        chk("same_first", 64'(In), 64'h1111);
        Req0 = 1'b0;
        step();
        chk("same_second", 64'(In), 64'h2222);
        Req1 = 1'b0;
        step();
        chk("same_reg5", 64'(phys_regs[5]), 64'h2222);

        // Hazard on a pending write to register 9.
        Req0 = 1'b1; Addr0 = 4'd9; Data0 = 16'h0909;
        step();
        Req0 = 1'b0; SelectA = 4'd9; SelectB = 4'd2;
        #1;
        chk("haz_pend_a", 64'(HazardA), 64'd1);
        chk("haz_pend_b", 64'(HazardB), 64'd0);
        step();

        // Clear sweep with requester 1 waiting; a mid-sweep ClearReq is ignored.
        Req1 = 1'b1; Addr1 = 4'd7; Data1 = 16'h7777; ClearReq = 1'b1;
        step();
        chk("clr_no_ack1", 64'(o_ack1), 64'd0);
        chk("clr_sel0", 64'(SelectInput), 64'd0);
        ClearReq = 1'b0;
        for (int i = 1; i < int'(NR); i++) begin
            ClearReq = (i == 5);
            step();
            chk("clr_sel", 64'(SelectInput), 64'(i));
            chk("clr_in", 64'(In), 64'd0);
            chk("clr_haz_a", 64'(HazardA), 64'd1);
        end
        ClearReq = 1'b0;
        step();
        chk("clr_done", 64'(ClearDone), 64'd1);
        chk("clr_busy_off", 64'(Busy), 64'd0);
        step();
        chk("clr_ack1_after", 64'(o_ack1), 64'd1);
        Req1 = 1'b0;
        step();

        // Reset on the seventh CLEAR cycle aborts without ClearDone.
        ClearReq = 1'b1;
        step();
        ClearReq = 1'b0;
        for (int i = 0; i < 6; i++) step();
        Reset = 1'b0;
        step();
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_we", 64'(WriteEnable), 64'd0);
        chk("abort_done", 64'(ClearDone), 64'd0);
        Reset = 1'b1;
        step();
        chk("abort_done_after", 64'(ClearDone), 64'd0);

        // Random traffic: requesters hold address/data until acknowledged.
        for (int c = 0; c < 600; c++) begin
            if (!Req0 && $urandom_range(0, 2) != 0) begin
                Req0 = 1'b1; Addr0 = AW'($urandom); Data0 = DW'($urandom);
            end
            if (!Req1 && $urandom_range(0, 2) != 0) begin
                Req1 = 1'b1; Addr1 = AW'($urandom); Data1 = DW'($urandom);
            end
            ClearReq = ($urandom_range(0, 39) == 0);
            Reset    = ($urandom_range(0, 149) != 0);
            SelectA  = AW'($urandom);
            SelectB  = AW'($urandom);
            step();
            if (e_ack0) Req0 = 1'b0;
            if (e_ack1) Req1 = 1'b0;
        end

        Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0; ClearReq = 1'b0;
        for (int i = 0; i < int'(NR) + 2; i++) step();
        for (int i = 0; i < int'(NR); i++) begin
            chk("final_regfile", 64'(phys_regs[i]), 64'(ref_regs[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
